// File: rtl/peak_event_monitor.sv
// peak_event_monitor: measures peak-to-peak period of the load/store peak flag,
// validates it against a legal window and raises a sticky alarm after repeated
// consecutive violations or timeouts.
module peak_event_monitor #(
  parameter int unsigned PBITS      = 16,
  parameter int unsigned PMIN       = 29990,
  parameter int unsigned PMAX       = 30010,
  parameter int unsigned ECBITS     = 8,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  input  logic              clr,
  output logic              period_valid,
  output logic [PBITS-1:0]  last_period,
  output logic              period_ok,
  output logic              timeout,
  output logic [ECBITS-1:0] event_count,
  output logic [2:0]        miss_count,
  output logic              alarm
);

  localparam int unsigned  MBITS   = 3;
  localparam logic [PBITS-1:0]  PMIN_V  = PBITS'(PMIN);
  localparam logic [PBITS-1:0]  PMAX_V  = PBITS'(PMAX);
  localparam logic [MBITS-1:0]  LIMIT_V = MBITS'(MISS_LIMIT);
  localparam logic [ECBITS-1:0] EC_MAX  = {ECBITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t             state, state_n;
  logic               sig_d;
  logic [PBITS-1:0]   cnt, cnt_n;
  logic [PBITS-1:0]   last_period_n;
  logic               period_ok_n;
  logic               period_valid_n;
  logic               timeout_n;
  logic [ECBITS-1:0]  event_count_n;
  logic [MBITS-1:0]   miss_count_n;
  logic               alarm_n;

  logic               rise;
  logic               in_window;
  logic [ECBITS-1:0]  event_inc;
  logic [MBITS-1:0]   miss_inc;

  // Rising edge of the peak flag; a level held high is a single event.
  assign rise      = sig & ~sig_d;
  assign in_window = (cnt >= PMIN_V) && (cnt <= PMAX_V);
  assign event_inc = (event_count == EC_MAX) ? event_count : event_count + ECBITS'(1);
  assign miss_inc  = (miss_count >= LIMIT_V) ? LIMIT_V : miss_count + MBITS'(1);

  // Next-state and next-output logic; clr dominates any edge or timeout.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    last_period_n  = last_period;
    period_ok_n    = period_ok;
    period_valid_n = 1'b0;
    timeout_n      = 1'b0;
    event_count_n  = event_count;
    miss_count_n   = miss_count;

    if (clr) begin
      state_n       = IDLE;
      cnt_n         = '0;
      event_count_n = '0;
      miss_count_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            cnt_n         = PBITS'(1);
            event_count_n = event_inc;
            state_n       = RUN;
          end
        end
        RUN: begin
          if (rise) begin
            // A rise exactly at PMAX is a legal period, not a timeout.
            last_period_n  = cnt;
            period_ok_n    = in_window;
            period_valid_n = 1'b1;
            event_count_n  = event_inc;
            cnt_n          = PBITS'(1);
            if (in_window) begin
              miss_count_n = '0;
            end else begin
              miss_count_n = miss_inc;
              if (miss_inc == LIMIT_V) state_n = ALARM;
            end
          end else if (cnt == PMAX_V) begin
            // No edge within the window: report, then resync on the next edge.
            timeout_n    = 1'b1;
            miss_count_n = miss_inc;
            cnt_n        = '0;
            state_n      = (miss_inc == LIMIT_V) ? ALARM : IDLE;
          end else begin
            cnt_n = cnt + PBITS'(1);
          end
        end
        ALARM: begin
          state_n = ALARM;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign alarm_n = (state_n == ALARM);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sig_d        <= 1'b0;
      cnt          <= '0;
      last_period  <= '0;
      period_ok    <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      event_count  <= '0;
      miss_count   <= '0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      sig_d        <= sig;
      cnt          <= cnt_n;
      last_period  <= last_period_n;
      period_ok    <= period_ok_n;
      period_valid <= period_valid_n;
      timeout      <= timeout_n;
      event_count  <= event_count_n;
      miss_count   <= miss_count_n;
      alarm        <= alarm_n;
    end
  end

endmodule

// File: tb/tb_peak_event_monitor.sv
// Directed bench for peak_event_monitor with a timestamp-based reference model.
module tb_peak_event_monitor;

  localparam int unsigned PBITS  = 16;
  localparam int unsigned PMIN   = 8;
  localparam int unsigned PMAX   = 12;
  localparam int unsigned ECBITS = 8;
  localparam int unsigned LIM    = 2;
  localparam int          EVMAX  = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              sig;
  logic              clr;
  logic              period_valid;
  logic [PBITS-1:0]  last_period;
  logic              period_ok;
  logic              timeout;
  logic [ECBITS-1:0] event_count;
  logic [2:0]        miss_count;
  logic              alarm;

  int checks = 0;
  int errors = 0;
  int n_to   = 0;

  // Reference model: edge timestamps instead of a running counter.
  int m_cyc   = 0;
  int m_last  = 0;
  bit m_armed = 0;
  bit m_prev  = 0;
  bit m_alarm = 0;
  bit m_pv    = 0;
  bit m_to    = 0;
  bit m_ok    = 0;
  int m_ev    = 0;
  int m_miss  = 0;
  int m_lp    = 0;

  peak_event_monitor #(
    .PBITS(PBITS), .PMIN(PMIN), .PMAX(PMAX), .ECBITS(ECBITS), .MISS_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .clr(clr),
    .period_valid(period_valid), .last_period(last_period), .period_ok(period_ok),
    .timeout(timeout), .event_count(event_count), .miss_count(miss_count),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cyc = 0; m_last = 0; m_armed = 0; m_prev = 0; m_alarm = 0;
    m_pv = 0; m_to = 0; m_ok = 0; m_ev = 0; m_miss = 0; m_lp = 0;
  endtask

  task automatic model_step();
    bit r;
    int per;
    m_cyc = m_cyc + 1;
    r = sig && !m_prev;
    m_prev = sig;
    m_pv = 0;
    m_to = 0;
    if (clr) begin
      m_armed = 0; m_alarm = 0; m_ev = 0; m_miss = 0;
    end else if (m_alarm) begin
      m_alarm = 1;
    end else if (r) begin
      if (m_armed) begin
        per = m_cyc - m_last;
        m_lp = per;
        m_ok = (per >= int'(PMIN)) && (per <= int'(PMAX));
        m_pv = 1;
        if (m_ok) m_miss = 0;
        else if (m_miss < int'(LIM)) m_miss = m_miss + 1;
        if (m_miss == int'(LIM)) m_alarm = 1;
      end
      if (m_ev < EVMAX) m_ev = m_ev + 1;
      m_armed = 1;
      m_last = m_cyc;
    end else if (m_armed && (m_cyc - m_last == int'(PMAX))) begin
      m_to = 1;
      m_armed = 0;
      if (m_miss < int'(LIM)) m_miss = m_miss + 1;
      if (m_miss == int'(LIM)) m_alarm = 1;
    end
  endtask

  // Model advances on every clock edge and on asynchronous reset.
  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock, then compare every output against the model mid-cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (timeout) n_to = n_to + 1;
    chk("period_valid", int'(period_valid), int'(m_pv));
    chk("timeout", int'(timeout), int'(m_to));
    chk("last_period", int'(last_period), m_lp);
    chk("period_ok", int'(period_ok), int'(m_ok));
    chk("event_count", int'(event_count), m_ev);
    chk("miss_count", int'(miss_count), m_miss);
    chk("alarm", int'(alarm), int'(m_alarm));
  endtask

  // Peak of h high cycles followed by l low cycles; captures outputs after the rising edge.
  task automatic pulse(input int h, input int l, output int pv, output int lp,
                       output int ok, output int ms, output int al);
    sig = 1'b1;
    tick();
    pv = int'(period_valid); lp = int'(last_period); ok = int'(period_ok);
    ms = int'(miss_count); al = int'(alarm);
    for (int i = 1; i < h; i++) tick();
    sig = 1'b0;
    for (int i = 0; i < l; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pv"}, int'(period_valid), 0);
    chk({tag, "_to"}, int'(timeout), 0);
    chk({tag, "_lp"}, int'(last_period), 0);
    chk({tag, "_ok"}, int'(period_ok), 0);
    chk({tag, "_ev"}, int'(event_count), 0);
    chk({tag, "_miss"}, int'(miss_count), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
  endtask

  initial begin : stim
    int pv, lp, ok, ms, al;
    rst = 1'b1; sig = 1'b0; clr = 1'b0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // 1: period 10 pulses x4
    pulse(1, 9, pv, lp, ok, ms, al);
    chk("t1_first_pv", pv, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(1, 9, pv, lp, ok, ms, al);
      chk("t1_pv", pv, 1); chk("t1_lp", lp, 10); chk("t1_ok", ok, 1);
    end
    chk("t1_ev", int'(event_count), 4);
    chk("t1_miss", int'(miss_count), 0);
    chk("t1_alarm", int'(alarm), 0);

    // 2: wide peaks, then period 12 at the window edge
    n_to = 0;
    pulse(2, 8, pv, lp, ok, ms, al);  chk("t2_lp_a", lp, 10);
    pulse(2, 8, pv, lp, ok, ms, al);  chk("t2_lp_b", lp, 10);
    pulse(1, 11, pv, lp, ok, ms, al); chk("t2_lp_c", lp, 10);
    pulse(1, 11, pv, lp, ok, ms, al); chk("t2_lp_12", lp, 12); chk("t2_ok_12", ok, 1);
    pulse(1, 4, pv, lp, ok, ms, al);  chk("t2_lp_12b", lp, 12); chk("t2_ok_12b", ok, 1);
    chk("t2_no_timeout", n_to, 0);
    chk("t2_ev", int'(event_count), 9);

    // 3: short period then legal period
    pulse(1, 9, pv, lp, ok, ms, al);
    chk("t3_lp5", lp, 5); chk("t3_ok5", ok, 0); chk("t3_miss1", ms, 1);
    n_to = 0;
    pulse(1, 19, pv, lp, ok, ms, al);
    chk("t3_lp10", lp, 10); chk("t3_ok10", ok, 1); chk("t3_miss0", ms, 0);

    // 4: timeout during the 19 low cycles above
    chk("t4_to_count", n_to, 1);
    chk("t4_miss", int'(miss_count), 1);
    pulse(1, 9, pv, lp, ok, ms, al);
    chk("t4_resync_pv", pv, 0); chk("t4_resync_miss", ms, 1);
    chk("t4_ev", int'(event_count), 12);

    // 5: two short periods -> alarm, then clr with a simultaneous rise
    pulse(1, 4, pv, lp, ok, ms, al); chk("t5_lp10", lp, 10); chk("t5_miss0", ms, 0);
    pulse(1, 4, pv, lp, ok, ms, al); chk("t5_lp5a", lp, 5); chk("t5_miss1", ms, 1);
    pulse(1, 4, pv, lp, ok, ms, al);
    chk("t5_trig_pv", pv, 1); chk("t5_miss2", ms, 2); chk("t5_alarm", al, 1);
    pulse(1, 8, pv, lp, ok, ms, al);
    pulse(1, 4, pv, lp, ok, ms, al);
    chk("t5_frozen_pv", pv, 0);
    chk("t5_frozen_ev", int'(event_count), 15);
    chk("t5_frozen_lp", int'(last_period), 5);
    chk("t5_alarm_hold", int'(alarm), 1);
    sig = 1'b1; clr = 1'b1;
    tick();
    chk("t5_clr_alarm", int'(alarm), 0);
    chk("t5_clr_ev", int'(event_count), 0);
    chk("t5_clr_miss", int'(miss_count), 0);
    chk("t5_clr_lp_kept", int'(last_period), 5);
    sig = 1'b0; clr = 1'b0;
    tick(); tick(); tick();
    pulse(1, 9, pv, lp, ok, ms, al);
    chk("t5_after_clr_pv", pv, 0);
    chk("t5_after_clr_ev", int'(event_count), 1);
    pulse(1, 9, pv, lp, ok, ms, al);
    chk("t5_after_clr_lp", lp, 10);

    // 6: asynchronous reset mid-count, then saturate the event counter
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) pulse(1, 9, pv, lp, ok, ms, al);
    chk("t6_ev_sat", int'(event_count), 255);
    chk("t6_lp", int'(last_period), 10);
    chk("t6_alarm", int'(alarm), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_event_monitor.md
Name: peak_event_monitor

Overview:
- Downstream consumer of the load/store peak flag `sig`, which is high while the volume counter sits at its ceiling.
- Detects each rising edge of `sig` and measures the period in cycles between consecutive peaks.
- Checks each period against a legal window and counts peak events and consecutive bad periods.
- Raises a sticky alarm after too many consecutive violations, for system-level supervision of the load/store oscillation.

Parameters:
PBITS, 16, width of period counter and last_period (must hold PMAX)
PMIN, 29990, minimum legal peak-to-peak period in cycles
PMAX, 30010, maximum legal period; no edge by PMAX means timeout
ECBITS, 8, width of saturating event counter
MISS_LIMIT, 3, consecutive bad periods/timeouts that trigger alarm (1..7)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
sig  in  1  peak flag from upstream load/store stage, synchronous to clk
clr  in  1  synchronous clear: exits ALARM, clears counters
period_valid  out  1  one-cycle pulse, new last_period/period_ok available
last_period  out  PBITS  most recently measured period
period_ok  out  1  last_period within [PMIN, PMAX]
timeout  out  1  one-cycle pulse, no edge within PMAX cycles
event_count  out  ECBITS  rising edges seen since reset/clr, saturates at all-ones
miss_count  out  3  consecutive bad periods plus timeouts
alarm  out  1  high while in ALARM state

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sig_d=0, cnt=0.
  - All outputs 0: last_period=0, period_ok=0, period_valid=0, timeout=0, event_count=0, miss_count=0, alarm=0.
- Edge detect: rise = sig & ~sig_d, with sig_d registered each cycle. If sig is high on the first cycle after reset, that counts as a rise. A level held high for several cycles is one event.
- States: IDLE, RUN, ALARM.
- IDLE:
  - Counter is stopped.
  - On rise: cnt<=1, event_count+1 (saturating), go RUN. No period is reported.
- RUN, no rise:
  - If cnt==PMAX: pulse timeout next cycle, miss_count+1, cnt<=0, go IDLE (resync on the next edge).
  - Otherwise cnt<=cnt+1.
- RUN, rise (edges P cycles apart, so cnt==P at the second edge):
  - last_period<=cnt, period_ok<=(PMIN<=cnt<=PMAX), period_valid pulses the next cycle.
  - event_count+1 (saturating), cnt<=1, stay in RUN.
  - Legal period: miss_count<=0.
  - Illegal period: miss_count+1.
- A rise and cnt==PMAX on the same cycle is a legal period, not a timeout.
- Alarm entry: when the updated miss_count equals MISS_LIMIT, go ALARM on that same update.
  - alarm=1 from the cycle after entry.
  - The triggering period_valid or timeout pulse is still emitted.
- ALARM:
  - Counter and all measurement state are frozen; sig is ignored except that sig_d keeps tracking.
  - event_count does not advance.
  - Only clr leaves ALARM.
- clr (any state): next cycle state=IDLE, cnt=0, event_count=0, miss_count=0, alarm=0.
  - last_period and period_ok are retained.
  - clr overrides a simultaneous rise (the rise is discarded) and a simultaneous timeout.
- Reset mid-operation: immediate return to reset values; a measurement in progress is lost.
- period_valid and timeout are never high on the same cycle and are always single-cycle pulses.
- Arithmetic:
  - cnt never exceeds PMAX and never wraps.
  - miss_count saturates at MISS_LIMIT.
  - Comparisons are unsigned, PBITS wide.

Test Plan:
Use PMIN=8, PMAX=12, MISS_LIMIT=2 for the directed bench.
1. Reset, then 1-cycle sig pulses every 10 cycles x4 -> first edge no report; three period_valid with last_period=10, period_ok=1; event_count=4, miss_count=0, alarm=0.
2. sig held high 2 cycles per peak, period 10 -> still one event per peak, last_period=10; peaks with spacing 12 accepted (period_ok=1, no timeout).
3. Edges spaced 5 then 10 -> period_valid with last_period=5, period_ok=0, miss_count=1; next period 10 -> period_ok=1, miss_count=0.
4. After one edge, sig stays low 20 cycles -> timeout pulse exactly once, at cnt==12; state IDLE, miss_count=1; next edge starts a new measurement with no report.
5. Periods 5, 5 -> miss_count=2, alarm=1 after the second period_valid; further pulses leave event_count and last_period unchanged; clr asserted together with a sig rise -> alarm=0, event_count=0, state IDLE, that rise ignored.
6. Assert rst asynchronously mid-count (between clock edges) -> all outputs 0 immediately; 300 edges at period 10 -> event_count saturates at 255.
